// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, bus payloads and the stall-mask encoder for the pipeline controller.
package pipe_ctrl_pkg;

    // Bus widths
    localparam int unsigned STALL_W = 5;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STATE_W = 2;

    // Stall bus bit positions, front of the pipe first
    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IF_DEC = 1;
    localparam int unsigned STALL_DEC_EX = 2;
    localparam int unsigned STALL_EX_LS  = 3;
    localparam int unsigned STALL_LS_WB  = 4;

    // Control levels
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Controller state encodings
    localparam logic [STATE_W-1:0] ST_RUN   = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_PEND  = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_DRAIN = STATE_W'(2);

    // A PC redirect request: valid strobe plus target
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } redirect_t;

    // Freeze every stage up to and including the requester; later stages get a bubble.
    function automatic logic [STALL_W-1:0] stall_mask(
        input logic ls,
        input logic ex,
        input logic dec,
        input logic fetch
    );
        logic [STALL_W-1:0] m;
        m = {STALL_W{NO_STOP}};
        if (ls || ex || dec || fetch) begin
            m[STALL_PC]     = STOP;
            m[STALL_IF_DEC] = STOP;
        end
        if (ls || ex || dec) begin
            m[STALL_DEC_EX] = STOP;
        end
        if (ls || ex) begin
            m[STALL_EX_LS] = STOP;
        end
        if (ls) begin
            m[STALL_LS_WB] = STOP;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall masks, flush/redirect sequencing around
// load/store stalls, stale-fetch discard and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallreq_if_i,
    input  logic              stallreq_dec_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_ls_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic [STALL_W-1:0] stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              fetch_discard_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    redirect_t          req_c;
    logic [STALL_W-1:0] mask_c;
    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic               redirect_c;
    logic [ADDR_W-1:0]  redirect_addr_c;
    logic               fetch_discard_c;

    // Pick the redirect source: a trap always beats a jump resolved in the same cycle.
    always_comb begin
        req_c.valid = trap_req_i | jump_req_i;
        req_c.addr  = '0;
        if (trap_req_i) begin
            req_c.addr = trap_addr_i;
        end else if (jump_req_i) begin
            req_c.addr = jump_addr_i;
        end
    end

    // Priority stall mask from the furthest-down requesting stage.
    always_comb begin
        mask_c = stall_mask(stallreq_ls_i, stallreq_ex_i, stallreq_dec_i, stallreq_if_i);
    end

    // Next-state and Mealy outputs; a redirect waits in PEND while memory holds LS.
    always_comb begin
        state_d         = state_q;
        pend_addr_d     = pend_addr_q;
        stall_c         = mask_c;
        flush_c         = DISABLE;
        redirect_c      = DISABLE;
        redirect_addr_c = '0;
        fetch_discard_c = DISABLE;

        case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (state_q == ST_DRAIN) begin
                    fetch_discard_c = ENABLE;
                    if (!stallreq_if_i) begin
                        state_d = ST_RUN;
                    end
                end
                if (req_c.valid) begin
                    if (stallreq_ls_i) begin
                        // Cannot flush under a stuck load/store; park the target.
                        pend_addr_d = req_c.addr;
                        stall_c     = {STALL_W{STOP}};
                        state_d     = ST_PEND;
                    end else begin
                        flush_c         = ENABLE;
                        redirect_c      = ENABLE;
                        redirect_addr_c = req_c.addr;
                        stall_c         = {STALL_W{NO_STOP}};
                        // An outstanding fetch will return stale data; drop it.
                        if (stallreq_if_i || (state_q == ST_DRAIN)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end

            ST_PEND: begin
                if (stallreq_ls_i) begin
                    stall_c = {STALL_W{STOP}};
                end else begin
                    flush_c         = ENABLE;
                    redirect_c      = ENABLE;
                    redirect_addr_c = pend_addr_q;
                    stall_c         = {STALL_W{NO_STOP}};
                    state_d         = stallreq_if_i ? ST_DRAIN : ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Count cycles with the PC frozen, sticking at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_c[STALL_PC] == STOP) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, parked target and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign stall_o         = rst_n ? stall_c : {STALL_W{NO_STOP}};
    assign flush_o         = rst_n ? flush_c : DISABLE;
    assign redirect_o      = rst_n ? redirect_c : DISABLE;
    assign redirect_addr_o = rst_n ? redirect_addr_c : '0;
    assign fetch_discard_o = rst_n ? fetch_discard_c : DISABLE;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_if_i, stallreq_dec_i, stallreq_ex_i, stallreq_ls_i;
    logic        jump_req_i, trap_req_i;
    logic [31:0] jump_addr_i, trap_addr_i;
    logic [4:0]  stall_o;
    logic        flush_o, redirect_o, fetch_discard_o;
    logic [31:0] redirect_addr_o, stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_drain;
    logic [31:0] m_cnt;

    typedef struct {
        logic [3:0]  req;   // {ls, ex, dec, if}
        logic        jump;
        logic [31:0] jaddr;
        logic        trap;
        logic [31:0] taddr;
        logic [4:0]  e_stall;
        logic        e_flush;
        logic        e_redir;
        logic [31:0] e_raddr;
        logic        e_disc;
    } vec_t;

    pipe_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_dec_i  (stallreq_dec_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_ls_i   (stallreq_ls_i),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .trap_req_i      (trap_req_i),
        .trap_addr_i     (trap_addr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .fetch_discard_o (fetch_discard_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [3:0] req, input logic j, input logic [31:0] ja,
                                input logic t, input logic [31:0] ta, input logic [4:0] es,
                                input logic ef, input logic er, input logic [31:0] ea,
                                input logic ed);
        vec_t v;
        v.req = req; v.jump = j; v.jaddr = ja; v.trap = t; v.taddr = ta;
        v.e_stall = es; v.e_flush = ef; v.e_redir = er; v.e_raddr = ea; v.e_disc = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_pend_addr = '0; m_drain = 0; m_cnt = '0;
    endtask

    task automatic drive(input vec_t v);
        {stallreq_ls_i, stallreq_ex_i, stallreq_dec_i, stallreq_if_i} = v.req;
        jump_req_i = v.jump; jump_addr_i = v.jaddr;
        trap_req_i = v.trap; trap_addr_i = v.taddr;
    endtask

    task automatic check_quiet(input string name);
        check({name, ".stall"}, 32'(stall_o), 32'd0);
        check({name, ".flush"}, 32'(flush_o), 32'd0);
        check({name, ".redir"}, 32'(redirect_o), 32'd0);
        check({name, ".raddr"}, redirect_addr_o, 32'd0);
        check({name, ".disc"}, 32'(fetch_discard_o), 32'd0);
        check({name, ".cnt"}, stall_cnt_o, 32'd0);
    endtask

    // One clock cycle: drive, compare against the model (and table if given), advance model.
    task automatic step(input vec_t v, input bit use_exp, input string name);
        bit          ls, ex, dec, ifr, req;
        int          n;
        logic [31:0] tgt, e_raddr;
        logic [4:0]  e_stall;
        bit          e_flush, e_redir, e_disc;

        drive(v);
        {ls, ex, dec, ifr} = v.req;
        req = v.jump | v.trap;
        tgt = v.trap ? v.taddr : v.jaddr;
        n = ls ? 5 : ex ? 4 : dec ? 3 : ifr ? 2 : 0;
        e_stall = 5'((32'd1 << n) - 32'd1);
        e_flush = 0; e_redir = 0; e_raddr = '0;
        e_disc  = m_drain && !m_pend;
        if (m_pend || req) begin
            if (ls) begin
                e_stall = 5'h1F;
            end else begin
                e_stall = 5'h00; e_flush = 1; e_redir = 1;
                e_raddr = m_pend ? m_pend_addr : tgt;
            end
        end

        @(negedge clk);
        check({name, ".stall"}, 32'(stall_o), 32'(e_stall));
        check({name, ".flush"}, 32'(flush_o), 32'(e_flush));
        check({name, ".redir"}, 32'(redirect_o), 32'(e_redir));
        check({name, ".raddr"}, redirect_addr_o, e_raddr);
        check({name, ".disc"}, 32'(fetch_discard_o), 32'(e_disc));
        check({name, ".cnt"}, stall_cnt_o, m_cnt);
        if (use_exp) begin
            check({name, ".tbl_stall"}, 32'(stall_o), 32'(v.e_stall));
            check({name, ".tbl_flush"}, 32'(flush_o), 32'(v.e_flush));
            check({name, ".tbl_redir"}, 32'(redirect_o), 32'(v.e_redir));
            check({name, ".tbl_raddr"}, redirect_addr_o, v.e_raddr);
            check({name, ".tbl_disc"}, 32'(fetch_discard_o), 32'(v.e_disc));
        end

        @(posedge clk);
        if (m_pend) begin
            if (!ls) begin
                m_pend  = 0;
                m_drain = ifr;
            end
        end else if (req && ls) begin
            m_pend = 1; m_pend_addr = tgt; m_drain = 0;
        end else if (req) begin
            m_drain = m_drain | ifr;
        end else begin
            m_drain = m_drain & ifr;
        end
        if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    vec_t tbl[$];
    vec_t seq[$];
    vec_t rv;

    initial begin
        // Reset with hostile inputs: everything must stay quiet.
        rst_n = 1'b0;
        drive(mk(4'b1111, 1, 32'hFFFF_FFF0, 1, 32'hAAAA_0000, 0, 0, 0, 0, 0));
        #3;
        check_quiet("reset_async");
        @(posedge clk); #1;
        check_quiet("reset_clocked");
        drive(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // Single-cycle RUN behaviour
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 0, 0, 5'h03, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 5'h07, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 5'h07, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 0, 0, 0, 5'h0F, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 0, 0, 0, 0, 5'h1F, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0011, 0, 0, 0, 0, 5'h07, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0111, 0, 0, 0, 0, 5'h0F, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 0, 0, 0, 0, 5'h1F, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 32'h8000_0100, 0, 0, 5'h00, 1, 1, 32'h8000_0100, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 32'h8000_0100, 1, 32'h8000_0004, 5'h00, 1, 1, 32'h8000_0004, 0));
        tbl.push_back(mk(4'b0110, 1, 32'h0000_4000, 0, 0, 5'h00, 1, 1, 32'h0000_4000, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 32'h0000_1234, 5'h00, 1, 1, 32'h0000_1234, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Redirect held off by LS stall for three cycles; new requests ignored meanwhile.
        seq = {};
        seq.push_back(mk(4'b1000, 1, 32'h8000_0200, 0, 0, 5'h1F, 0, 0, 0, 0));
        seq.push_back(mk(4'b1000, 1, 32'hDEAD_0000, 0, 0, 5'h1F, 0, 0, 0, 0));
        seq.push_back(mk(4'b1000, 0, 0, 1, 32'h1111_0000, 5'h1F, 0, 0, 0, 0));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 1, 1, 32'h8000_0200, 0));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        for (int i = 0; i < seq.size(); i++) step(seq[i], 1'b1, $sformatf("pend%0d", i));

        // Redirect with fetch outstanding: discard through the cycle IF releases.
        seq = {};
        seq.push_back(mk(4'b0001, 1, 32'h8000_0300, 0, 0, 5'h00, 1, 1, 32'h8000_0300, 0));
        seq.push_back(mk(4'b0001, 0, 0, 0, 0, 5'h03, 0, 0, 0, 1));
        seq.push_back(mk(4'b0001, 0, 0, 0, 0, 5'h03, 0, 0, 0, 1));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 1));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        for (int i = 0; i < seq.size(); i++) step(seq[i], 1'b1, $sformatf("drain%0d", i));

        // Redirect while draining stays in drain for one more cycle.
        seq = {};
        seq.push_back(mk(4'b0001, 1, 32'h8000_0400, 0, 0, 5'h00, 1, 1, 32'h8000_0400, 0));
        seq.push_back(mk(4'b0000, 1, 32'h8000_0500, 0, 0, 5'h00, 1, 1, 32'h8000_0500, 1));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 1));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        // Redirect while draining under LS stall parks the target.
        seq.push_back(mk(4'b0001, 1, 32'h8000_0600, 0, 0, 5'h00, 1, 1, 32'h8000_0600, 0));
        seq.push_back(mk(4'b1000, 0, 0, 1, 32'h8000_0700, 5'h1F, 0, 0, 0, 1));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 1, 1, 32'h8000_0700, 0));
        seq.push_back(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0));
        for (int i = 0; i < seq.size(); i++) step(seq[i], 1'b1, $sformatf("dredir%0d", i));

        // Reset in the middle of PEND drops the parked redirect.
        step(mk(4'b1000, 1, 32'h8000_0800, 0, 0, 5'h1F, 0, 0, 0, 0), 1'b1, "rpend0");
        step(mk(4'b1000, 0, 0, 0, 0, 5'h1F, 0, 0, 0, 0), 1'b1, "rpend1");
        drive(mk(4'b1000, 1, 32'h8000_0900, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        check_quiet("rpend_rst");
        drive(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        #1;
        check_quiet("rpend_rel");
        @(posedge clk); #1;
        step(mk(4'b0000, 0, 0, 0, 0, 5'h00, 0, 0, 0, 0), 1'b1, "rpend2");
        step(mk(4'b0001, 0, 0, 0, 0, 5'h03, 0, 0, 0, 0), 1'b1, "rpend3");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rv = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            rv.req[0] = ($urandom_range(0, 3) == 0);
            rv.req[1] = ($urandom_range(0, 4) == 0);
            rv.req[2] = ($urandom_range(0, 5) == 0);
            rv.req[3] = ($urandom_range(0, 2) == 0);
            rv.jump   = ($urandom_range(0, 4) == 0);
            rv.trap   = ($urandom_range(0, 9) == 0);
            rv.jaddr  = $urandom;
            rv.taddr  = $urandom;
            step(rv, 1'b0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
